// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the sequential BCD-to-binary converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BCD_DIGITS = 10;
    localparam int unsigned ACC_W      = 34;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_mac10.sv
// Combinational multiply-by-ten-and-add step: acc_o = acc_i*10 + digit_i.
module bcd_mac10
    import bcd_pkg::*;
(
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [ACC_W-1:0]   acc_o
);

    always_comb begin
        acc_o = (acc_i << 3) + (acc_i << 1) + {{(ACC_W-DIGIT_W){1'b0}}, digit_i};
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter, one digit per clock, MSD first.
// Define BCD2BIN_ERR_CHK_EN to flag digits above 9 and results above 2^32-1.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned NDIG  = 10,
    parameter int unsigned OUT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIGIT_W*BCD_DIGITS-1:0] bcd_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              bin_out,
    output logic                          err,
    output logic                          busy
);

    localparam int unsigned SR_W = DIGIT_W * NDIG;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_next;
    logic [3:0]         cnt_q, cnt_d;
    logic [OUT_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [DIGIT_W-1:0] digit;

    assign digit = sr_q[SR_W-1 -: DIGIT_W];

    bcd_mac10 u_mac (
        .acc_i   (acc_q),
        .digit_i (digit),
        .acc_o   (acc_next)
    );

`ifdef BCD2BIN_ERR_CHK_EN
    logic err_flag_q, err_flag_d;
    logic digit_bad, err_fin;

    assign digit_bad = (digit > 4'd9);
    assign err_fin   = err_flag_q | digit_bad | (|acc_next[ACC_W-1:OUT_W]);
`endif

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
`ifdef BCD2BIN_ERR_CHK_EN
        err_flag_d = err_flag_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d    = bcd_in[SR_W-1:0];
                    acc_d   = '0;
                    cnt_d   = 4'(NDIG - 1);
                    state_d = CONV;
`ifdef BCD2BIN_ERR_CHK_EN
                    err_flag_d = 1'b0;
`endif
                end
            end
            CONV: begin
                acc_d = acc_next;
                sr_d  = sr_q << DIGIT_W;
                cnt_d = cnt_q - 4'd1;
`ifdef BCD2BIN_ERR_CHK_EN
                err_flag_d = err_flag_q | digit_bad;
`endif
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
`ifdef BCD2BIN_ERR_CHK_EN
                    bin_d = err_fin ? '0 : acc_next[OUT_W-1:0];
                    err_d = err_fin;
`else
                    bin_d = acc_next[OUT_W-1:0];
                    err_d = 1'b0;
`endif
                end
            end
            DONE: begin
                // A coincident in_valid is left pending for the next IDLE cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bin_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef BCD2BIN_ERR_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q <= 1'b0;
        end else begin
            err_flag_q <= err_flag_d;
        end
    end
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bin_out   = bin_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed self-checking bench for bcd_to_bin_seq (default NDIG=10).
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] bin_out;
    logic        err;
    logic        busy;

    int unsigned total_cnt;
    int unsigned pass_cnt;
    logic [31:0] held;

    bcd_to_bin_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the accept edge until out_valid, bounded to 20.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (out_valid) break;
        end
        check({tag, "_latency"}, 32'(n), 32'd10);
    endtask

    task automatic convert(input string tag, input logic [39:0] bcd,
                           input logic [31:0] exp_bin, input logic exp_err);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        bcd_in   = bcd;
        tick();
        in_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_not_ready"}, {31'd0, in_ready}, 32'd0);
        wait_out(tag);
        check({tag, "_bin"}, bin_out, exp_bin);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_consumed"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_bin", bin_out, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        convert("zero", 40'h00_0000_0000, 32'h0000_0000, 1'b0);
        convert("max", 40'h42_9496_7295, 32'hFFFF_FFFF, 1'b0);
`ifdef BCD2BIN_ERR_CHK_EN
        convert("ovf", 40'h42_9496_7297, 32'h0000_0000, 1'b1);
        convert("baddig", 40'h00_0000_001A, 32'h0000_0000, 1'b1);
`else
        convert("ovf", 40'h42_9496_7297, 32'h0000_0001, 1'b0);
        convert("baddig", 40'h00_0000_001A, 32'h0000_0014, 1'b0);
`endif

        // Backpressure: 12345678 = 0xBC614E held while out_ready is low.
        in_valid = 1'b1;
        bcd_in   = 40'h00_1234_5678;
        tick();
        in_valid = 1'b0;
        wait_out("bp");
        held = bin_out;
        check("bp_bin", held, 32'h00BC_614E);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_stable", bin_out, 32'h00BC_614E);
            check("bp_valid_held", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end

        // Operand offered together with out_ready: accepted one IDLE cycle later.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bcd_in    = 40'h00_0000_0099;
        tick();
        check("b2b0_idle_ready", {31'd0, in_ready}, 32'd1);
        check("b2b0_idle_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("b2b0_busy", {31'd0, busy}, 32'd1);
        wait_out("b2b0");
        check("b2b0_bin", bin_out, 32'h0000_0063);
        in_valid = 1'b1;
        bcd_in   = 40'h00_0001_2345;
        tick();
        check("b2b1_idle_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b1_busy", {31'd0, busy}, 32'd1);
        wait_out("b2b1");
        check("b2b1_bin", bin_out, 32'h0000_3039);
        tick();
        out_ready = 1'b0;
        check("b2b1_consumed", {31'd0, out_valid}, 32'd0);

        // Reset during the 5th CONV cycle.
        in_valid = 1'b1;
        bcd_in   = 40'h98_7654_3210;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        convert("after_rst", 40'h00_0000_0010, 32'h0000_000A, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
